// File: rtl/rail_fence_pkg.sv
// rail_fence_pkg: shared FSM states and widths for the rail-fence stream front end
package rail_fence_pkg;
    typedef enum logic [1:0] {S_RECV, S_START, S_WAIT, S_SEND} state_t;
    localparam int BLOCK_W = 256;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/rail_fence_stream_ctrl_byte_shift_buffer.sv
// byte_shift_buffer: block-wide register with parallel load and byte-wise left shift
module byte_shift_buffer
    import rail_fence_pkg::*;
#(
    parameter int W = BLOCK_W
) (
    input  logic              i_clk,
    input  logic              i_rst_new,
    input  logic              i_load,
    input  logic [W-1:0]      i_load_data,
    input  logic              i_shift,
    input  logic [BYTE_W-1:0] i_shift_in,
    output logic [W-1:0]      o_data
);
    logic [W-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_new)
        if (!i_rst_new)
            r_data <= '0;
        else if (i_load)
            r_data <= i_load_data;
        else if (i_shift)
            r_data <= {r_data[W-BYTE_W-1:0], i_shift_in};

    assign o_data = r_data;
endmodule

// File: rtl/rail_fence_stream_ctrl.sv
// rail_fence_stream_ctrl: assembles rx bytes into a block, runs the core, streams plain text back out
module rail_fence_stream_ctrl
    import rail_fence_pkg::*;
#(
    parameter int BYTES   = BLOCK_W / BYTE_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst_new,
    input  logic                    i_rx_valid,
    output logic                    o_rx_ready,
    input  logic [7:0]              i_rx_data,
    output logic                    o_start,
    output logic [BYTE_W*BYTES-1:0] o_enc,
    input  logic                    i_finished,
    input  logic [BYTE_W*BYTES-1:0] i_dec,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic [7:0]              o_tx_data,
    output logic                    o_busy,
    output logic                    o_timeout
);
    localparam int W  = BYTE_W * BYTES;
    localparam int CW = $clog2(BYTES + 1);
    localparam int TW = $clog2(TIMEOUT);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_wait;
    logic          r_timeout;
    logic          w_rx_hs, w_tx_hs, w_last, w_fin, w_to;
    logic [W-1:0]  w_dec_buf;

    assign o_rx_ready = r_state == S_RECV;
    assign o_start    = r_state == S_START;
    assign o_tx_valid = r_state == S_SEND;
    assign o_busy     = !(r_state == S_RECV && r_cnt == '0);
    assign o_timeout  = r_timeout;
    assign o_tx_data  = w_dec_buf[W-1 -: BYTE_W];
    assign w_rx_hs    = i_rx_valid & o_rx_ready;
    assign w_tx_hs    = o_tx_valid & i_tx_ready;
    assign w_last     = r_cnt == CW'(BYTES - 1);
    assign w_fin      = r_state == S_WAIT && i_finished;
    assign w_to       = r_state == S_WAIT && !i_finished && r_wait == TW'(TIMEOUT - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RECV:  w_next = (w_rx_hs && w_last) ? S_START : S_RECV;
            S_START: w_next = S_WAIT;
            S_WAIT:  w_next = w_fin ? S_SEND : (w_to ? S_RECV : S_WAIT);
            S_SEND:  w_next = (w_tx_hs && w_last) ? S_RECV : S_SEND;
            default: w_next = S_RECV;
        endcase
    end

    // one byte counter serves both directions; only one handshake kind is possible per state
    always_ff @(posedge i_clk or negedge i_rst_new)
        if (!i_rst_new) begin
            r_state   <= S_RECV;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_rx_hs || w_tx_hs)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (r_state == S_WAIT)
                r_wait <= (w_fin || w_to) ? '0 : r_wait + 1'b1;
            if (w_to)
                r_timeout <= 1'b1;
            else if (w_rx_hs)
                r_timeout <= 1'b0;
        end

    byte_shift_buffer #(.W(W)) u_rx (
        .i_clk       (i_clk),
        .i_rst_new   (i_rst_new),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift     (w_rx_hs),
        .i_shift_in  (i_rx_data),
        .o_data      (o_enc)
    );

    byte_shift_buffer #(.W(W)) u_tx (
        .i_clk       (i_clk),
        .i_rst_new   (i_rst_new),
        .i_load      (w_fin),
        .i_load_data (i_dec),
        .i_shift     (w_tx_hs),
        .i_shift_in  (8'h00),
        .o_data      (w_dec_buf)
    );
endmodule

// File: tb/tb_rail_fence_stream_ctrl.sv
// tb_rail_fence_stream_ctrl: vector table, hand sequences and random blocks against a byte-level model
module tb_rail_fence_stream_ctrl;
    localparam int BYTES = 32;
    localparam int TIMEOUT = 1024;
    localparam int W = 8 * BYTES;

    typedef logic [7:0] barr_t [BYTES];
    typedef struct {
        logic [7:0]   base;
        logic [7:0]   step;
        logic [W-1:0] dec;
        logic [W-1:0] exp_enc;
        int           fin_dly;
        int           gap;
        bit           rnd;
    } vec_t;

    logic         i_clk = 0, i_rst_new = 1, i_rx_valid = 0, i_finished = 0, i_tx_ready = 0;
    logic [7:0]   i_rx_data = 0;
    logic [W-1:0] i_dec = 0;
    logic         o_rx_ready, o_start, o_tx_valid, o_busy, o_timeout;
    logic [W-1:0] o_enc;
    logic [7:0]   o_tx_data;

    int checks = 0, failures = 0, cyc = 0, n_start = 0, exp_starts = 0;

    rail_fence_stream_ctrl #(.BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst_new(i_rst_new), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .i_rx_data(i_rx_data), .o_start(o_start), .o_enc(o_enc), .i_finished(i_finished),
        .i_dec(i_dec), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;
    always @(negedge i_clk) if (o_start) n_start++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_blk();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // model: first received byte lands in the most significant byte
    function automatic logic [W-1:0] pack(input barr_t b);
        logic [W-1:0] v = '0;
        for (int i = 0; i < BYTES; i++) v[8*(BYTES-1-i) +: 8] = b[i];
        return v;
    endfunction

    task automatic push_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge i_clk);
        i_rx_valid = 1;
        i_rx_data = b;
        while (!o_rx_ready && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_rx_ready) chk("rx_ready_wait", o_rx_ready, 1);
        @(negedge i_clk);
        i_rx_valid = 0;
    endtask

    task automatic recv_block(input logic [W-1:0] dec, input bit rnd, output int first_c, output int last_c);
        int k = 0, guard = 0;
        logic [7:0] prev = 0;
        bit stall = 0;
        first_c = 0;
        last_c = 0;
        while (k < BYTES && guard < 5000) begin
            if (stall) chk("tx_hold", {o_tx_valid, o_tx_data}, {1'b1, prev});
            i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_tx_valid && i_tx_ready) begin
                chk($sformatf("tx_byte%0d", k), o_tx_data, dec[8*(BYTES-1-k) +: 8]);
                if (k == 0) first_c = cyc;
                last_c = cyc;
                k++;
            end
            stall = o_tx_valid && !i_tx_ready;
            prev = o_tx_data;
            @(negedge i_clk);
            guard++;
        end
        i_tx_ready = 0;
        if (k != BYTES) chk("tx_count", k, BYTES);
    endtask

    task automatic finish_and_recv(input logic [W-1:0] exp_enc, input logic [W-1:0] dec,
                                   input int fin_dly, input bit rnd, input string tag);
        int f, l;
        @(negedge i_clk);
        chk({tag, "_start_len"}, o_start, 0);
        repeat (fin_dly) @(negedge i_clk);
        chk({tag, "_enc_hold"}, o_enc, exp_enc);
        i_finished = 1;
        i_dec = dec;
        @(negedge i_clk);
        i_finished = 0;
        i_dec = rnd_blk();
        chk({tag, "_txv"}, o_tx_valid, 1);
        recv_block(dec, rnd, f, l);
        if (!rnd) chk({tag, "_span"}, l - f, 31);
        chk({tag, "_txv_end"}, o_tx_valid, 0);
        chk({tag, "_rdy_end"}, o_rx_ready, 1);
    endtask

    task automatic run_block(input barr_t rx, input logic [W-1:0] exp_enc, input logic [W-1:0] dec,
                             input int fin_dly, input bit rnd, input int gap, input string tag);
        for (int i = 0; i < BYTES; i++) push_byte(rx[i], gap);
        exp_starts++;
        chk({tag, "_start"}, o_start, 1);
        chk({tag, "_enc"}, o_enc, exp_enc);
        finish_and_recv(exp_enc, dec, fin_dly, rnd, tag);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"}, o_rx_ready, 1);
        chk({tag, "_start"}, o_start, 0);
        chk({tag, "_enc"}, o_enc, 0);
        chk({tag, "_txv"}, o_tx_valid, 0);
        chk({tag, "_txd"}, o_tx_data, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_to"}, o_timeout, 0);
    endtask

    initial begin
        vec_t  tbl[3];
        barr_t rx;
        tbl[0] = '{8'h00, 8'h01, {32{8'hA5}},
                   256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F, 2, 0, 1'b0};
        tbl[1] = '{8'hFF, 8'hFF, 256'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0EFEEEDECEBEAE9E8E7E6E5E4E3E2E1E0,
                   256'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0EFEEEDECEBEAE9E8E7E6E5E4E3E2E1E0, 5, 0, 1'b1};
        tbl[2] = '{8'h10, 8'h11, {4{64'h0123456789ABCDEF}},
                   256'h102132435465768798A9BACBDCEDFE0F2031425364758697A8B9CADBECFD0E1F, 0, 2, 1'b1};

        #3 i_rst_new = 0;
        #2 chk_reset("rst");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_new = 1;

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < BYTES; i++) rx[i] = 8'(tbl[v].base + tbl[v].step * i);
            run_block(rx, tbl[v].exp_enc, tbl[v].dec, tbl[v].fin_dly, tbl[v].rnd, tbl[v].gap,
                      $sformatf("vec%0d", v));
        end

        // rx held valid through wait/send; an early finish during start is ignored
        for (int i = 0; i < BYTES; i++) push_byte(8'(i + 8'h40), 0);
        exp_starts++;
        chk("hold_start", o_start, 1);
        i_finished = 1;
        i_dec = {32{8'h5A}};
        i_rx_valid = 1;
        i_rx_data = 8'h77;
        @(negedge i_clk);
        i_finished = 0;
        chk("hold_fin_ignored", o_tx_valid, 0);
        chk("hold_rdy_wait", o_rx_ready, 0);
        begin
            logic [W-1:0] d = rnd_blk();
            int f, l;
            repeat (3) @(negedge i_clk);
            i_finished = 1;
            i_dec = d;
            @(negedge i_clk);
            i_finished = 0;
            chk("hold_rdy_send", o_rx_ready, 0);
            recv_block(d, 1'b1, f, l);
        end
        chk("hold_rdy_after", o_rx_ready, 1);
        rx[0] = 8'h77;
        push_byte(8'h77, 0);
        for (int i = 1; i < BYTES; i++) begin
            rx[i] = 8'(8'hC0 + i);
            push_byte(rx[i], 0);
        end
        exp_starts++;
        chk("hold_enc", o_enc, pack(rx));
        finish_and_recv(pack(rx), rnd_blk(), 1, 1'b1, "hold");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < BYTES; i++) rx[i] = 8'($urandom);
            run_block(rx, pack(rx), rnd_blk(), $urandom_range(0, 15), 1'b1, $urandom_range(0, 2),
                      $sformatf("rnd%0d", r));
        end

        // timeout: no finish ever arrives
        for (int i = 0; i < BYTES; i++) push_byte(8'($urandom), 0);
        exp_starts++;
        chk("to_start", o_start, 1);
        repeat (TIMEOUT) @(negedge i_clk);
        chk("to_early", o_timeout, 0);
        chk("to_wait_rdy", o_rx_ready, 0);
        @(negedge i_clk);
        chk("to_set", o_timeout, 1);
        chk("to_rdy", o_rx_ready, 1);
        chk("to_busy", o_busy, 0);
        i_finished = 1;
        i_dec = rnd_blk();
        @(negedge i_clk);
        i_finished = 0;
        chk("to_fin_ignored", o_tx_valid, 0);
        chk("to_sticky", o_timeout, 1);
        push_byte(8'h3C, 0);
        chk("to_clear", o_timeout, 0);
        chk("to_busy_rx", o_busy, 1);

        // asynchronous reset after 10 bytes of a partial block
        for (int i = 1; i < 10; i++) push_byte(8'($urandom), 0);
        #2 i_rst_new = 0;
        #1 chk_reset("mid_rst");
        @(negedge i_clk);
        i_rst_new = 1;
        @(negedge i_clk);
        chk("post_rst_start", o_start, 0);
        for (int i = 0; i < BYTES; i++) rx[i] = 8'(8'h80 + 3 * i);
        run_block(rx, pack(rx), rnd_blk(), 2, 1'b0, 0, "post_rst");

        @(negedge i_clk);
        #1 chk("start_pulses", n_start, exp_starts);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
